// File: rtl/dadda_pkg.sv
// Shared Dadda multiplier definitions: height sequence, stage count, row pair, adder cells.
package dadda_pkg;

    localparam int unsigned DADDA_N = 6;
    localparam int unsigned DADDA_D [DADDA_N] = '{2, 3, 4, 6, 9, 13};
    localparam int unsigned ROW_W = 32;

    // Final two rows of the tree, as handed to the carry-propagate adder.
    typedef struct packed {
        logic [ROW_W-1:0] row_s;
        logic [ROW_W-1:0] row_c;
    } row_pair_t;

    // Number of reduction stages: every sequence height below the operand width.
    function automatic int unsigned dadda_stages(input int unsigned width);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(DADDA_N); i++) begin
            if (DADDA_D[3'(i)] < width) n++;
        end
        return n;
    endfunction

    // Half adder cell: {carry, sum}.
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder cell: {carry, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

endpackage

// File: rtl/dadda_tree.sv
// Combinational AND-array plus Dadda reduction of a*b down to two rows.
module dadda_tree
    import dadda_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] row_s,
    output logic [2*WIDTH-1:0] row_c
);

    localparam int unsigned NC = 2 * WIDTH;
    localparam int unsigned CW = $clog2(NC);
    localparam int unsigned HW = $clog2(WIDTH);
    localparam int unsigned NS = dadda_stages(WIDTH);
    localparam logic [HW:0] H1 = (HW+1)'(1);

    // Per-column bit lists (cur) and their heights (h); nxt/hn build the next stage.
    logic [WIDTH-1:0] cur [NC];
    logic [WIDTH-1:0] nxt [NC];
    logic [HW:0]      h   [NC];
    logic [HW:0]      hn  [NC];
    logic [1:0]       hs;
    logic [CW-1:0]    ci;
    int               d;
    int               take;
    int               tot;

    // Partial products, then one Dadda stage per target height, largest first.
    always_comb begin
        hs    = '0;
        ci    = '0;
        d     = 0;
        take  = 0;
        tot   = 0;
        row_s = '0;
        row_c = '0;
        for (int c = 0; c < int'(NC); c++) begin
            cur[CW'(c)] = '0;
            nxt[CW'(c)] = '0;
            h[CW'(c)]   = '0;
            hn[CW'(c)]  = '0;
        end

        for (int i = 0; i < int'(WIDTH); i++) begin
            for (int j = 0; j < int'(WIDTH); j++) begin
                cur[CW'(i+j)][h[CW'(i+j)][HW-1:0]] = a[HW'(i)] & b[HW'(j)];
                h[CW'(i+j)] = h[CW'(i+j)] + H1;
            end
        end

        for (int s = int'(NS) - 1; s >= 0; s--) begin
            d = int'(DADDA_D[3'(s)]);
            for (int c = 0; c < int'(NC); c++) begin
                nxt[CW'(c)] = '0;
                hn[CW'(c)]  = '0;
            end
            for (int c = 0; c < int'(NC); c++) begin
                ci   = CW'(c);
                take = 0;
                // Spend just enough adders to bring this column (incoming carries included) down to d.
                for (int k = 0; k < int'(WIDTH); k++) begin
                    tot = int'(h[ci]) - take + int'(hn[ci]);
                    if (tot > d) begin
                        if (tot == d + 1) begin
                            hs   = ha(cur[ci][HW'(take)], cur[ci][HW'(take+1)]);
                            take = take + 2;
                        end else begin
                            hs   = fa(cur[ci][HW'(take)], cur[ci][HW'(take+1)], cur[ci][HW'(take+2)]);
                            take = take + 3;
                        end
                        nxt[ci][hn[ci][HW-1:0]] = hs[0];
                        hn[ci] = hn[ci] + H1;
                        // Carries out of the top column are dropped (result is mod 2^NC).
                        if (c + 1 < int'(NC)) begin
                            nxt[CW'(c+1)][hn[CW'(c+1)][HW-1:0]] = hs[1];
                            hn[CW'(c+1)] = hn[CW'(c+1)] + H1;
                        end
                    end
                end
                // Untouched bits pass straight through to the next stage.
                for (int k = 0; k < int'(WIDTH); k++) begin
                    if (k >= take && k < int'(h[ci])) begin
                        nxt[ci][hn[ci][HW-1:0]] = cur[ci][HW'(k)];
                        hn[ci] = hn[ci] + H1;
                    end
                end
            end
            for (int c = 0; c < int'(NC); c++) begin
                cur[CW'(c)] = nxt[CW'(c)];
                h[CW'(c)]   = hn[CW'(c)];
            end
        end

        for (int c = 0; c < int'(NC); c++) begin
            row_s[CW'(c)] = cur[CW'(c)][0];
            row_c[CW'(c)] = cur[CW'(c)][1];
        end
    end

endmodule

// File: rtl/dadda_reduce_stage.sv
// Two-register pipeline around the Dadda tree with valid/ready flow control.
module dadda_reduce_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] row_s,
    output logic [2*WIDTH-1:0] row_c,
    output logic [1:0]         occupancy
);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               v1;
    logic               s1_adv;
    logic               accept;
    logic               s2_load;
    logic               v1_nxt;
    logic               v2_nxt;
    logic [2*WIDTH-1:0] tree_s;
    logic [2*WIDTH-1:0] tree_c;

    dadda_tree #(.WIDTH(WIDTH)) u_tree (
        .a     (a_q),
        .b     (b_q),
        .row_s (tree_s),
        .row_c (tree_c)
    );

    // Ready chain and next valid bits; S2 may drain while S1 refills in the same edge.
    always_comb begin
        s1_adv   = !out_valid || out_ready;
        in_ready = !rst && (!v1 || s1_adv);
        accept   = in_valid && in_ready && !flush;
        s2_load  = v1 && s1_adv;
        v1_nxt   = accept || (v1 && !s1_adv);
        v2_nxt   = s2_load || (out_valid && !out_ready);
    end

    // S1/S2 registers; reset clears everything, flush only drops the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            row_s     <= '0;
            row_c     <= '0;
            occupancy <= '0;
        end else begin
            if (flush) begin
                v1        <= 1'b0;
                out_valid <= 1'b0;
                occupancy <= '0;
            end else begin
                v1        <= v1_nxt;
                out_valid <= v2_nxt;
                occupancy <= {1'b0, v1_nxt} + {1'b0, v2_nxt};
            end
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (s2_load && !flush) begin
                row_s <= tree_s;
                row_c <= tree_c;
            end
        end
    end

endmodule

// File: tb/tb_dadda_reduce_stage.sv
// Self-checking bench: directed scenarios plus a randomized run against a product queue.
module tb_dadda_reduce_stage;
    import dadda_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned RW = 2 * W;
    localparam int unsigned NRAND = 10000;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] row_s;
    logic [RW-1:0] row_c;
    logic [1:0]    occupancy;

    int total = 0;
    int bad   = 0;

    // Products of accepted pairs not yet delivered, oldest first.
    logic [RW-1:0] expq [$];

    always #5 clk = ~clk;

    dadda_reduce_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_s     (row_s),
        .row_c     (row_c),
        .occupancy (occupancy)
    );

    // Downstream 32-bit adder with cin tied to 0.
    function automatic logic [RW-1:0] adder32(input row_pair_t p);
        logic [RW:0] t;
        t = {1'b0, p.row_s} + {1'b0, p.row_c};
        return t[RW-1:0];
    endfunction

    function automatic row_pair_t rows_now();
        row_pair_t p;
        p.row_s = row_s;
        p.row_c = row_c;
        return p;
    endfunction

    // Called at the negative edge: account for this cycle's transfers, then cross the next rising edge.
    task automatic step();
        if (rst || flush) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready && expq.size() > 0) void'(expq.pop_front());
            if (in_valid && in_ready) expq.push_back(RW'(a) * RW'(b));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; a = 16'h00AA; b = 16'h0055; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
        total++; if (row_s !== '0 || row_c !== '0) begin bad++; $display("FAIL rst_rows got=%h/%h want=0/0", row_s, row_c); end
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", in_ready); end
        step();
    endtask

    task automatic test_max_operands();
        logic [RW-1:0] s;
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL max_accept got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL max_early got=%b want=0", out_valid); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL max_occ got=%0d want=1", occupancy); end
        step();
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL max_latency got=%b want=1", out_valid); end
        s = adder32(rows_now());
        total++; if (s !== 32'hFFFE0001) begin bad++; $display("FAIL max_product got=%h want=fffe0001", s); end
        total++; if (row_c[0] !== 1'b0) begin bad++; $display("FAIL max_rowc0 got=%b want=0", row_c[0]); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  pa [3];
        logic [W-1:0]  pb [3];
        logic [RW-1:0] want [3];
        logic [RW-1:0] s;
        logic          exp_v;
        int            got;
        pa = '{16'd3, 16'h8000, 16'd0};
        pb = '{16'd5, 16'd2, 16'h1234};
        want = '{32'd15, 32'h0001_0000, 32'd0};
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin in_valid = 1'b1; a = pa[i]; b = pb[i]; end
            else in_valid = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, in_ready); end
            end
            exp_v = (i >= 2 && i <= 4);
            total++; if (out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=%b", i, out_valid, exp_v); end
            if (out_valid === 1'b1 && got < 3) begin
                s = adder32(rows_now());
                total++; if (s !== want[got]) begin bad++; $display("FAIL b2b_sum[%0d] got=%h want=%h", got, s, want[got]); end
                got++;
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  pa [3];
        logic [W-1:0]  pb [3];
        logic [RW-1:0] want [3];
        logic [RW-1:0] hs;
        logic [RW-1:0] hc;
        logic [RW-1:0] s;
        int            idx;
        int            got;
        pa = '{16'd11, 16'hFFFF, 16'h1234};
        pb = '{16'd13, 16'd1, 16'h0010};
        want = '{32'd143, 32'h0000_FFFF, 32'h0001_2340};
        idx = 0; got = 0; hs = '0; hc = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = pa[idx]; b = pb[idx];
            @(negedge clk);
            if (i >= 2) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, in_ready); end
                total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ[%0d] got=%0d want=2", i, occupancy); end
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, out_valid); end
            end
            if (i == 2) begin
                hs = row_s; hc = row_c;
                s = adder32(rows_now());
                total++; if (s !== want[0]) begin bad++; $display("FAIL bp_head got=%h want=%h", s, want[0]); end
            end
            if (i == 3) begin
                total++; if (row_s !== hs || row_c !== hc) begin bad++; $display("FAIL bp_stable got=%h/%h want=%h/%h", row_s, row_c, hs, hc); end
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", idx); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin a = pa[idx]; b = pb[idx]; end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                s = adder32(rows_now());
                total++;
                if (got >= 3) begin bad++; $display("FAIL bp_extra got=%h want=none", s); end
                else if (s !== want[got]) begin bad++; $display("FAIL bp_drain[%0d] got=%h want=%h", got, s, want[got]); end
                got++;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        total++; if (got !== 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got); end
    endtask

    task automatic test_reset_midop();
        logic [RW-1:0] s;
        int            got;
        got = 0;
        out_ready = 1'b0; in_valid = 1'b1; a = 16'd21; b = 16'd3;
        @(negedge clk); step();
        a = 16'd100; b = 16'd4;
        @(negedge clk); step();
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rm_fill got=%0d want=2", occupancy); end
        step();
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rm_occ got=%0d want=0", occupancy); end
        total++; if (row_s !== '0 || row_c !== '0) begin bad++; $display("FAIL rm_rows got=%h/%h want=0/0", row_s, row_c); end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'd7; b = 16'd9;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                s = adder32(rows_now());
                total++; if (got != 0 || s !== 32'd63) begin bad++; $display("FAIL rm_result[%0d] got=%h want=3f", got, s); end
                got++;
            end
            step();
        end
        total++; if (got !== 1) begin bad++; $display("FAIL rm_count got=%0d want=1", got); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h0055; b = 16'h0066;
        @(negedge clk); step();
        flush = 1'b1; a = 16'h0077; b = 16'h0088;
        @(negedge clk);
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL fl_pre_occ got=%0d want=1", occupancy); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL fl_occ got=%0d want=0", occupancy); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid[%0d] got=%b want=0", i, out_valid); end
            step();
        end
    endtask

    task automatic test_random();
        logic          pend;
        logic          hold;
        logic [RW-1:0] hs;
        logic [RW-1:0] hc;
        logic [RW-1:0] s;
        logic          exp_rdy;
        int            sent;
        int            recv;
        int            cyc;
        int unsigned   r;
        pend = 1'b0; hold = 1'b0; hs = '0; hc = '0;
        sent = 0; recv = 0; cyc = 0;
        while ((sent < int'(NRAND) || expq.size() > 0) && cyc < 60000) begin
            if (!pend && sent < int'(NRAND) && $urandom_range(3) != 0) begin
                pend = 1'b1;
                r = $urandom_range(7);
                a = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
                r = $urandom_range(7);
                b = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
            end
            in_valid  = pend;
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            total++; if (occupancy !== 2'(expq.size())) begin bad++; $display("FAIL rnd_occ@%0d got=%0d want=%0d", cyc, occupancy, expq.size()); end
            exp_rdy = (expq.size() < 2) || out_ready;
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready@%0d got=%b want=%b", cyc, in_ready, exp_rdy); end
            if (hold) begin
                total++; if (out_valid !== 1'b1 || row_s !== hs || row_c !== hc) begin bad++; $display("FAIL rnd_hold@%0d got=%b %h/%h want=1 %h/%h", cyc, out_valid, row_s, row_c, hs, hc); end
            end
            if (expq.size() == 0) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_spurious@%0d got=%b want=0", cyc, out_valid); end
            end else if (out_valid === 1'b1) begin
                s = adder32(rows_now());
                total++; if (s !== expq[0]) begin bad++; $display("FAIL rnd_product@%0d got=%h want=%h", cyc, s, expq[0]); end
                total++; if (row_c[0] !== 1'b0) begin bad++; $display("FAIL rnd_rowc0@%0d got=%b want=0", cyc, row_c[0]); end
            end
            hold = out_valid && !out_ready;
            hs = row_s; hc = row_c;
            if (in_valid && in_ready) begin pend = 1'b0; sent++; end
            if (out_valid && out_ready) recv++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (sent != int'(NRAND) || recv != int'(NRAND)) begin bad++; $display("FAIL rnd_count got=%0d/%0d want=%0d", sent, recv, NRAND); end
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
